serial_word_capture: RTL and testbench

SERIAL_WORD_CAPTURE -- requirements
Module: serial_word_capture

---
 rtl/serial_word_capture.sv | 94 +++++++++
 tb/tb_serial_word_capture.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_capture.sv
// serial_word_capture: MSB-first serial-to-parallel capture with a
// double-buffered output word and a valid/ready handshake.
// Optional feature macro: SWC_PARITY_CHECK_EN (one even-parity bit per frame).
module serial_word_capture #(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          din,
    input  logic                          din_valid,
    output logic [WIDTH-1:0]              word_out,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(WIDTH+2)-1:0]    bit_count,
    output logic                          overrun,
    output logic                          parity_err
);

`ifdef SWC_PARITY_CHECK_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    logic [WIDTH-1:0] shifter;
    logic [WIDTH-1:0] next_word;
    logic             last;
    logic             data_bit;
    logic             accept_word;

    assign last        = din_valid && (bit_count == LAST);
    // A completed word is taken only if the output slot is free or being drained.
    assign accept_word = last && (!word_valid || word_ready);

`ifdef SWC_PARITY_CHECK_EN
    logic next_par;
    // Parity bit is the final frame bit and never enters the shifter.
    assign data_bit  = din_valid && (bit_count < CW'(WIDTH));
    assign next_word = shifter;
    assign next_par  = (^shifter) ^ din;
`else
    assign data_bit  = din_valid;
    assign next_word = {shifter[WIDTH-2:0], din};
`endif

    // Count accepted bits, wrapping to zero on the frame's last bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bit_count <= '0;
        else if (din_valid)
            bit_count <= last ? '0 : bit_count + CW'(1);
    end

    // Shift data bits in at bit 0 so the first bit ends up as the MSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            shifter <= '0;
        else if (data_bit)
            shifter <= {shifter[WIDTH-2:0], din};
    end

    // Output word register, handshake and sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (accept_word) begin
                word_out   <= next_word;
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            if (last && word_valid && !word_ready)
                overrun <= 1'b1;
        end
    end

`ifdef SWC_PARITY_CHECK_EN
    // Parity status travels with the word it describes; dropped words leave it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            parity_err <= 1'b0;
        else if (accept_word)
            parity_err <= next_par;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_capture.sv
// Self-checking bench for serial_word_capture (WIDTH=8); follows the
// SWC_PARITY_CHECK_EN build setting for frame length and parity cases.
module tb_serial_word_capture;

    localparam int WIDTH = 8;
`ifdef SWC_PARITY_CHECK_EN
    localparam int FR = WIDTH + 1;
`else
    localparam int FR = WIDTH;
`endif

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       din;
    logic                       din_valid;
    logic [WIDTH-1:0]           word_out;
    logic                       word_valid;
    logic                       word_ready;
    logic [$clog2(WIDTH+2)-1:0] bit_count;
    logic                       overrun;
    logic                       parity_err;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        int         gap_at;
        int         gap_len;
        logic [7:0] exp_word;
    } vec_t;
    vec_t vecs[6];

    serial_word_capture #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .bit_count(bit_count), .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge, away from sampling.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: every handshake must deliver the oldest expected word.
    always @(negedge clk) begin
        if (!reset && word_valid && word_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %0h expected none", word_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (word_out !== e) begin
                    errors++;
                    $display("FAIL sb_word: got %0h expected %0h", word_out, e);
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] data, input bit bad_par, input int gap_at,
                              input int gap_len, input bit ready_last, input bit push,
                              output int rise_at);
        int n;
        n = 0;
        rise_at = -1;
        for (int i = 0; i < FR; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    din_valid = 1'b0;
                    din = 1'($urandom);
                    tick(); n++;
                    if (word_valid && rise_at < 0) rise_at = n;
                end
            end
            din = (i < 8) ? data[7-i] : ((^data) ^ bad_par);
            din_valid = 1'b1;
            if (ready_last && i == FR - 1) word_ready = 1'b1;
            tick(); n++;
            if (word_valid && rise_at < 0) rise_at = n;
        end
        din_valid = 1'b0;
        if (ready_last) word_ready = 1'b0;
        if (push) exp_q.push_back(data);
    endtask

    task automatic ready_pulse();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r030, r031, rd;
        vecs[0] = '{8'h00, -1, 0, 8'h00};
        vecs[1] = '{8'hFF, -1, 0, 8'hFF};
        vecs[2] = '{8'hA5,  0, 2, 8'hA5};
        vecs[3] = '{8'h3C,  7, 1, 8'h3C};
        vecs[4] = '{8'h81, -1, 0, 8'h81};
        vecs[5] = '{8'h7E,  4, 5, 8'h7E};

        reset = 1'b1; din = 1'b0; din_valid = 1'b0; word_ready = 1'b0;
        tick(); tick();
        check("rst_word_out",   word_out,   0);
        check("rst_word_valid", word_valid, 0);
        check("rst_bit_count",  bit_count,  0);
        check("rst_overrun",    overrun,    0);
        check("rst_parity_err", parity_err, 0);
        reset = 1'b0;

        // Basic frame 0xB2, no consumer
        send_frame(8'hB2, 1'b0, -1, 0, 1'b0, 1'b1, r030);
        check("f030_word",  word_out,   8'hB2);
        check("f030_valid", word_valid, 1);
        check("f030_count", bit_count,  0);
        check("f030_rise",  r030,       FR);

        // Second frame while held: dropped, overrun set
        send_frame(8'h0F, 1'b0, -1, 0, 1'b0, 1'b0, rd);
        check("ovr_word",    word_out,   8'hB2);
        check("ovr_valid",   word_valid, 1);
        check("ovr_overrun", overrun,    1);
        ready_pulse();
        check("ovr_drain_valid", word_valid, 0);
        check("ovr_sticky",      overrun,    1);

        // Same frame with a 3-cycle din_valid gap
        do_reset();
        check("rst2_overrun", overrun, 0);
        send_frame(8'hB2, 1'b0, 4, 3, 1'b0, 1'b1, r031);
        check("gap_word", word_out, 8'hB2);
        check("gap_rise", r031,     r030 + 3);

        // New word completes on the same edge as the handshake
        send_frame(8'h5A, 1'b0, -1, 0, 1'b1, 1'b1, rd);
        check("hs_word",    word_out,   8'h5A);
        check("hs_valid",   word_valid, 1);
        check("hs_overrun", overrun,    0);
        ready_pulse();
        check("hs_drain", word_valid, 0);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 5; i++) begin
            din = 1'b1; din_valid = 1'b1; tick();
        end
        din_valid = 1'b0;
        check("part_count", bit_count, 5);
        #1 reset = 1'b1;
        #1;
        check("arst_word_out",  word_out,   0);
        check("arst_valid",     word_valid, 0);
        check("arst_count",     bit_count,  0);
        check("arst_overrun",   overrun,    0);
        check("arst_parity",    parity_err, 0);
        #2 reset = 1'b0;
        send_frame(8'hFF, 1'b0, -1, 0, 1'b0, 1'b1, rd);
        check("post_rst_word", word_out, 8'hFF);
        check("post_rst_rise", rd,       FR);
        ready_pulse();

        // Table-driven frames with a consumer always ready
        word_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, 1'b0, vecs[v].gap_at, vecs[v].gap_len, 1'b0, 1'b1, rd);
            check($sformatf("tbl%0d_word", v),  word_out,   vecs[v].exp_word);
            check($sformatf("tbl%0d_valid", v), word_valid, 1);
            tick();
            check($sformatf("tbl%0d_drain", v), word_valid, 0);
        end
        word_ready = 1'b0;

`ifdef SWC_PARITY_CHECK_EN
        send_frame(8'hB2, 1'b0, -1, 0, 1'b0, 1'b1, rd);
        check("par_good_err",  parity_err, 0);
        check("par_good_word", word_out,   8'hB2);
        ready_pulse();
        send_frame(8'hB2, 1'b1, -1, 0, 1'b0, 1'b1, rd);
        check("par_bad_err",   parity_err, 1);
        check("par_bad_word",  word_out,   8'hB2);
        check("par_bad_valid", word_valid, 1);
        send_frame(8'h03, 1'b0, -1, 0, 1'b0, 1'b0, rd);
        check("par_drop_err",  parity_err, 1);
        ready_pulse();
`endif

        tick();
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
